data_mem_pipe: RTL and testbench
================================

# data_mem_pipe

Parametrised successor to the single-port data memory: word-addressed RAM with a valid/ready request port, per-byte write strobes, configurable pipelined read latency, out-of-range error reporting and a post-reset clear sweep. Sits between the pipeline's MEM stage and storage. Accepts one request per cycle and returns one in-order response per accepted request.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8
- ADDR_WIDTH, 32, request address width; word address, not byte address
- DEPTH, 256, number of words; addresses 0..DEPTH-1 valid
- READ_LATENCY, 1, cycles from accept edge to response; legal 1..4
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  DATA_WIDTH/8  byte-lane write enables; lane i = bits [8i+7:8i]
- resp_valid  out  1  response valid, one-cycle pulse per accepted request
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- resp_err  out  1  request address >= DEPTH
- init_done  out  1  clear sweep finished

## Operation
- Reset (rst_n low, async): req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0, latency pipeline flushed, FSM to INIT, clear counter 0. Array contents are not reset directly.
- FSM states: INIT, RUN.
  - INIT: each rising edge writes 0 to word[counter] and increments counter. The edge that clears word DEPTH-1 moves to RUN and sets init_done=1.
  - RUN: req_ready=1 every cycle. No further transitions except by reset.
- Accept = req_valid && req_ready at a rising edge. req_valid while req_ready=0 is ignored; no request is queued.
- Write accepted, addr < DEPTH: for each lane i with req_wstrb[i]=1, word[addr] lane i takes req_wdata lane i. Other lanes are unchanged. wstrb=0 is a legal no-op and is not an error.
- Read accepted, addr < DEPTH: samples word[addr] at the accept edge, after all writes committed on earlier edges.
- addr >= DEPTH, comparing the full ADDR_WIDTH with no truncation or wrap: memory is unchanged. The response has resp_err=1 and resp_rdata=0.
- Every accepted request, read or write, produces exactly one response, in acceptance order. Writes return resp_err and resp_rdata=0.
- There is no response backpressure. Responses are emitted unconditionally.

## Timing
- Request accepted at edge E. resp_valid, resp_rdata and resp_err are valid in the cycle following edge E+READ_LATENCY-1. For READ_LATENCY=1, that is the cycle immediately after E.
- Throughput: one request per cycle. Back-to-back accepts give back-to-back resp_valid.
- Between responses, resp_valid=0 and resp_rdata and resp_err are driven to 0.
- Write at edge E, then read of the same address at edge E+1: the read returns the new data.
- There is no same-edge read/write combination, because a request is either a read or a write.
- INIT duration: init_done and req_ready rise after exactly DEPTH rising edges with rst_n high.
- Reset mid-operation: in-flight responses are dropped, with no resp_valid after rst_n falls. On rst_n release the INIT sweep restarts from word 0.
- Asserting rst_n low during INIT restarts the sweep.

## Test plan
- Init sweep (DEPTH=16): release rst_n, then count edges. req_ready=0 and init_done=0 for 15 edges, both become 1 after edge 16. Reading every address returns 0 with resp_err=0.
- Write/read latency: write 0x00000007 to addr 4 with wstrb=4'hF, then read addr 4. With READ_LATENCY=1 the read response arrives 1 cycle after accept with rdata=0x00000007. With READ_LATENCY=3 it arrives 3 cycles after accept.
- Byte strobes: write 0xAABBCCDD to addr 2 (wstrb=F), then 0x11223344 with wstrb=4'b0101. A read returns 0xAA22CC44. A write with wstrb=0 leaves the word unchanged and gives resp_err=0.
- Pipelined stream: write addrs 0..7 with data 0x100+addr on consecutive cycles, then read addrs 0..7 on consecutive cycles. Expect 16 consecutive resp_valid pulses, in order, with the reads returning 0x100..0x107.
- Out of range (DEPTH=256): write 0xDEADBEEF to addr 256, then read 256 and 0xFFFFFFFF. All three responses have resp_err=1 and rdata=0. A read of addr 0 is unchanged and has resp_err=0.
- Reset mid-operation: issue 3 reads with READ_LATENCY=4, then pull rst_n low one cycle after the last accept. No resp_valid appears. req_ready=0 immediately. After release the INIT sweep reruns, and the earlier writes read back as 0.

Source files
------------

// File: rtl/data_mem_pipe.sv
// Word RAM with strobed writes, range checking and a post-reset clear sweep; responses READ_LATENCY cycles after accept, in order.
// Accepts one request per cycle once the sweep is done (req_ready low during INIT); responses have no backpressure.
module data_mem_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    init_done
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Range check is done one bit wider than either operand so nothing wraps.
    localparam int CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH + 1 : 33;
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_init_cnt;
    logic [IDX_W-1:0]        w_init_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [READ_LATENCY-1:0] r_pipe_err;
    logic [DATA_WIDTH-1:0]   r_pipe_dat [READ_LATENCY];

    logic                    w_accept;
    logic                    w_in_range;
    logic [IDX_W-1:0]        w_idx;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign req_ready  = (r_state == S_RUN);
    assign init_done  = (r_state == S_RUN);
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = (CMP_W'(req_addr) < DEPTH_C);
    assign w_idx      = req_addr[IDX_W-1:0];
    assign w_rd_word  = r_mem[w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            S_INIT: begin
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Storage itself has no reset; the INIT sweep zeroes it one word per edge.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_accept && req_write && w_in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (req_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            r_pipe_err <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_dat[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_accept;
            r_pipe_err[0] <= w_accept && !w_in_range;
            r_pipe_dat[0] <= (w_accept && !req_write && w_in_range) ? w_rd_word : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_err[i] <= r_pipe_err[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    assign resp_valid = r_pipe_vld[READ_LATENCY-1];
    assign resp_err   = r_pipe_err[READ_LATENCY-1];
    assign resp_rdata = r_pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: directed vector table, multi-cycle corner sequences and a
// randomized run checked every cycle against a queue-based memory model.
module tb_data_mem_pipe;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_done;

    data_mem_pipe #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH       (DEPTH),
        .READ_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          mon_chk = 0;
    int          mon_err = 0;
    int unsigned cyc = 0;
    int unsigned m_edges = 0;
    logic [31:0] mdl [DEPTH];
    exp_t        q [$];
    vec_t        tbl [14];
    bit          rec_v [32];
    logic [31:0] rec_d [32];

    // Reference model: after DEPTH clean edges memory is all zero and every
    // request is served in order, its result due LAT-1 edges after acceptance.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_edges = 0;
                for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
            end else begin
                cyc = cyc + 1;
                while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
                if (m_edges >= DEPTH && req_valid) begin
                    logic [31:0] d;
                    logic        e;
                    d = '0;
                    e = (req_addr >= 32'(DEPTH));
                    if (!e && req_write) begin
                        for (int l = 0; l < 4; l++)
                            if (req_wstrb[l]) mdl[req_addr][8*l +: 8] = req_wdata[8*l +: 8];
                    end else if (!e) begin
                        d = mdl[req_addr];
                    end
                    q.push_back('{cyc + LAT - 1, d, e});
                end
                if (m_edges < DEPTH) m_edges = m_edges + 1;
            end
        end
    end

    initial begin
        forever begin
            logic        ev;
            logic [31:0] ed;
            logic        ee;
            logic        er;
            @(negedge clk);
            ev = 1'b0; ed = '0; ee = 1'b0;
            if (rst_n && q.size() > 0 && q[0].due == cyc) begin
                ev = 1'b1; ed = q[0].rdata; ee = q[0].err;
            end
            er = rst_n && (m_edges >= DEPTH);
            mon_chk = mon_chk + 1;
            if (resp_valid !== ev || resp_rdata !== ed || resp_err !== ee ||
                req_ready !== er || init_done !== er) begin
                mon_err = mon_err + 1;
                $display("FAIL monitor cyc=%0d: got v=%b d=%h e=%b rdy=%b done=%b, required v=%b d=%h e=%b rdy=%b done=%b",
                         cyc, resp_valid, resp_rdata, resp_err, req_ready, init_done, ev, ed, ee, er, er);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input bit ok, input string name, input string detail);
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic send_wait(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic [31:0] exp_rd,
                             input logic exp_err, input string name);
        int k;
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (k = 0; k < int'(LAT) + 4; k++) begin
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check(got && k == int'(LAT) - 1, {name, "_latency"},
              $sformatf("got=%0b after %0d cycles, required %0d", got, k, LAT - 1));
        check(resp_rdata === exp_rd && resp_err === exp_err, name,
              $sformatf("rdata=%h err=%b, required rdata=%h err=%b", resp_rdata, resp_err, exp_rd, exp_err));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'd4,          32'h0000_0007, 4'hF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'd4,          32'h0,         4'h0, 32'h0000_0007, 1'b0};
        tbl[2]  = '{1'b1, 32'd2,          32'hAABB_CCDD, 4'hF, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b1, 32'd2,          32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b0, 32'd2,          32'h0,         4'h0, 32'hAA22_CC44, 1'b0};
        tbl[5]  = '{1'b1, 32'd2,          32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        tbl[6]  = '{1'b0, 32'd2,          32'h0,         4'h0, 32'hAA22_CC44, 1'b0};
        tbl[7]  = '{1'b1, 32'd16,         32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b1};
        tbl[8]  = '{1'b0, 32'd16,         32'h0,         4'h0, 32'h0000_0000, 1'b1};
        tbl[9]  = '{1'b0, 32'hFFFF_FFFF,  32'h0,         4'h0, 32'h0000_0000, 1'b1};
        tbl[10] = '{1'b1, 32'h8000_0004,  32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b0, 32'd4,          32'h0,         4'h0, 32'h0000_0007, 1'b0};
        tbl[12] = '{1'b1, 32'd15,         32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
        tbl[13] = '{1'b0, 32'd15,         32'h0,         4'h0, 32'h1234_5678, 1'b0};

        // Reset state, then the clear sweep edge by edge.
        repeat (3) @(posedge clk);
        #1;
        check(!req_ready && !init_done && !resp_valid && resp_rdata == 32'h0 && !resp_err, "reset_state",
              $sformatf("rdy=%b done=%b v=%b d=%h e=%b, required all 0",
                        req_ready, init_done, resp_valid, resp_rdata, resp_err));
        #1 rst_n = 1'b1;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            logic exp_r;
            @(posedge clk); #1;
            exp_r = (k == int'(DEPTH));
            check(req_ready === exp_r && init_done === exp_r, $sformatf("init_edge%0d", k),
                  $sformatf("rdy=%b done=%b, required %b", req_ready, init_done, exp_r));
        end

        for (int a = 0; a < int'(DEPTH); a++)
            send_wait(1'b0, 32'(a), 32'h0, 4'h0, 32'h0, 1'b0, $sformatf("init_zero_a%0d", a));

        for (int i = 0; i < 14; i++)
            send_wait(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb,
                      tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("vec%0d", i));

        // Back-to-back writes then reads: 16 consecutive responses.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk); #1;
                    req_valid = 1'b1; req_write = (i < 8); req_addr = 32'(i % 8);
                    req_wdata = 32'h100 + 32'(i % 8); req_wstrb = 4'hF;
                end
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 32; c++) begin
                    @(negedge clk);
                    rec_v[c] = resp_valid;
                    rec_d[c] = resp_rdata;
                end
            end
        join
        begin
            int f;
            f = -1;
            for (int c = 31; c >= 0; c--) if (rec_v[c]) f = c;
            check(f == int'(LAT) + 1, "stream_first",
                  $sformatf("first resp at cycle %0d, required %0d", f, LAT + 1));
            if (f < 0) f = 0;
            for (int j = 0; j < 16; j++) begin
                logic [31:0] ed;
                ed = (j < 8) ? 32'h0 : 32'h100 + 32'(j - 8);
                check(f + j < 32 && rec_v[f+j] && rec_d[f+j] === ed, $sformatf("stream_resp%0d", j),
                      $sformatf("v=%b d=%h, required v=1 d=%h", rec_v[f+j], rec_d[f+j], ed));
            end
            check(f + 16 < 32 && !rec_v[f+16], "stream_end",
                  $sformatf("v=%b after 16 responses, required 0", rec_v[f+16]));
        end

        // Randomized traffic; the per-cycle monitor compares against the model.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 1));
            req_wdata = $urandom;
            req_wstrb = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT + 2) @(posedge clk);

        // Reset with three reads in flight: nothing may come out.
        send_wait(1'b1, 32'd3, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "pre_rst_write");
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd3;
        @(posedge clk); #1;
        req_addr = 32'd5;
        @(posedge clk); #1;
        req_addr = 32'd6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check(!req_ready && !init_done && !resp_valid, "rst_mid_immediate",
              $sformatf("rdy=%b done=%b v=%b, required all 0", req_ready, init_done, resp_valid));
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < int'(LAT) + 2; c++) begin
                @(negedge clk);
                if (resp_valid) seen = seen + 1;
            end
            check(seen == 0, "rst_mid_dropped", $sformatf("%0d resp_valid pulses, required 0", seen));
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (DEPTH - 1) @(posedge clk);
        #1;
        check(!req_ready, "rst_reinit_busy", $sformatf("rdy=%b one edge before sweep end, required 0", req_ready));
        @(posedge clk); #1;
        check(req_ready && init_done, "rst_reinit_done",
              $sformatf("rdy=%b done=%b, required 1", req_ready, init_done));
        send_wait(1'b0, 32'd3, 32'h0, 4'h0, 32'h0, 1'b0, "post_rst_a3");
        send_wait(1'b0, 32'd2, 32'h0, 4'h0, 32'h0, 1'b0, "post_rst_a2");
        send_wait(1'b0, 32'd15, 32'h0, 4'h0, 32'h0, 1'b0, "post_rst_a15");

        repeat (2) @(posedge clk);
        checks = checks + mon_chk;
        errors = errors + mon_err;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
